// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared constants, FSM state type and helpers for the MEM stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] WB_SEL_ZERO = 2'b00;
  localparam logic [1:0] WB_SEL_ALU  = 2'b01;
  localparam logic [1:0] WB_SEL_MEM  = 2'b10;
  localparam logic [1:0] WB_SEL_PC4  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  // Access size is funct3[1:0]; the unsigned variants share the signed masks.
  function automatic logic [7:0] width_mask(input logic [1:0] size);
    case (size)
      2'b00:   width_mask = 8'h01;
      2'b01:   width_mask = 8'h03;
      2'b10:   width_mask = 8'h0F;
      default: width_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo[1:0];
      default: misaligned = |addr_lo;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_store_align.sv
// ============================================================================
// Module  : store_align
// Brief   : Combinational store-data/byte-enable alignment within a doubleword.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_align
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MASK_W = 8
) (
  input  logic [2:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   wdata,
  output logic [MASK_W-1:0] wmask
);

  logic [MASK_W-1:0] w_base_mask;

  assign w_base_mask = MASK_W'(width_mask(size));
  assign wdata       = rs2 << {addr_lo, 3'b000};
  // Enables shifted past the top byte simply fall off.
  assign wmask       = w_base_mask << addr_lo;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// Brief   : RV64 MEM stage with valid/ready data-memory port and MEM/WB register.
//           Optional macro MISALIGN_TRAP_EN: trap misaligned accesses to WB.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_mem,
  input  logic [XLEN-1:0]   pc_mem,
  input  logic [31:0]       inst_mem,
  input  logic [XLEN-1:0]   alu_result_mem,
  input  logic [XLEN-1:0]   rs2_data_mem,
  input  logic              re_mem,
  input  logic              we_mem,
  input  logic [1:0]        wb_sel_mem,
  input  logic [2:0]        memdata_width_mem,
  output logic              stall_mem,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              valid_wb,
  output logic [XLEN-1:0]   pc_wb,
  output logic [31:0]       inst_wb,
  output logic [1:0]        wb_sel_wb,
  output logic [XLEN-1:0]   alu_result_wb,
  output logic [XLEN-1:0]   data_in_wb,
  output logic [2:0]        memdata_width_wb,
  output logic              misalign_exc
);

  state_t            r_state;
  logic              w_memop;
  logic              w_misalign;
  logic              w_start;
  logic              w_resp;
  logic              w_idle_pass;
  logic              w_wb_load;
  logic [XLEN-1:0]   w_wdata;
  logic [MASK_W-1:0] w_wmask;

  store_align #(
    .XLEN   (XLEN),
    .MASK_W (MASK_W)
  ) u_store_align (
    .addr_lo (alu_result_mem[2:0]),
    .size    (memdata_width_mem[1:0]),
    .rs2     (rs2_data_mem),
    .wdata   (w_wdata),
    .wmask   (w_wmask)
  );

  assign w_memop = valid_mem && (re_mem || we_mem);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_memop && misaligned(memdata_width_mem[1:0], alu_result_mem[2:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start     = (r_state == ST_IDLE) && w_memop && !w_misalign;
  assign w_resp      = (r_state == ST_WAIT) && mem_resp_valid;
  assign w_idle_pass = (r_state == ST_IDLE) && !w_start;
  assign w_wb_load   = w_idle_pass || w_resp;

  assign mem_req_valid = (r_state == ST_REQ);
  assign stall_mem     = w_start || (r_state == ST_REQ) ||
                         ((r_state == ST_WAIT) && !mem_resp_valid);

  // Request fields are captured once so they stay stable through the handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_REQ;
            mem_addr  <= {alu_result_mem[XLEN-1:3], 3'b000};
            mem_we    <= we_mem;
            mem_wdata <= w_wdata;
            mem_wmask <= w_wmask;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_resp_valid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Upstream is frozen while stalled, so the EX/MEM inputs are still valid on the response cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_wb         <= 1'b0;
      pc_wb            <= '0;
      inst_wb          <= '0;
      wb_sel_wb        <= '0;
      alu_result_wb    <= '0;
      data_in_wb       <= '0;
      memdata_width_wb <= '0;
      misalign_exc     <= 1'b0;
    end else begin
      valid_wb     <= w_resp || (w_idle_pass && valid_mem);
      misalign_exc <= w_idle_pass && w_misalign;
      if (w_wb_load) begin
        pc_wb            <= pc_mem;
        inst_wb          <= inst_mem;
        wb_sel_wb        <= w_misalign ? WB_SEL_ZERO : wb_sel_mem;
        alu_result_wb    <= alu_result_mem;
        data_in_wb       <= (w_resp && !mem_we) ? mem_rdata : '0;
        memdata_width_wb <= memdata_width_mem;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module  : tb_mem_stage
// Brief   : Directed self-checking bench for mem_stage (honours MISALIGN_TRAP_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_mem;
  logic [63:0] pc_mem;
  logic [31:0] inst_mem;
  logic [63:0] alu_result_mem;
  logic [63:0] rs2_data_mem;
  logic        re_mem;
  logic        we_mem;
  logic [1:0]  wb_sel_mem;
  logic [2:0]  memdata_width_mem;
  logic        stall_mem;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic        valid_wb;
  logic [63:0] pc_wb;
  logic [31:0] inst_wb;
  logic [1:0]  wb_sel_wb;
  logic [63:0] alu_result_wb;
  logic [63:0] data_in_wb;
  logic [2:0]  memdata_width_wb;
  logic        misalign_exc;

  int n_pass  = 0;
  int n_total = 0;

  mem_stage dut (
    .clk               (clk),
    .rstn              (rstn),
    .valid_mem         (valid_mem),
    .pc_mem            (pc_mem),
    .inst_mem          (inst_mem),
    .alu_result_mem    (alu_result_mem),
    .rs2_data_mem      (rs2_data_mem),
    .re_mem            (re_mem),
    .we_mem            (we_mem),
    .wb_sel_mem        (wb_sel_mem),
    .memdata_width_mem (memdata_width_mem),
    .stall_mem         (stall_mem),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_addr          (mem_addr),
    .mem_we            (mem_we),
    .mem_wdata         (mem_wdata),
    .mem_wmask         (mem_wmask),
    .mem_resp_valid    (mem_resp_valid),
    .mem_rdata         (mem_rdata),
    .valid_wb          (valid_wb),
    .pc_wb             (pc_wb),
    .inst_wb           (inst_wb),
    .wb_sel_wb         (wb_sel_wb),
    .alu_result_wb     (alu_result_wb),
    .data_in_wb        (data_in_wb),
    .memdata_width_wb  (memdata_width_wb),
    .misalign_exc      (misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic idle_inputs();
    valid_mem = 1'b0; pc_mem = '0; inst_mem = '0; alu_result_mem = '0;
    rs2_data_mem = '0; re_mem = 1'b0; we_mem = 1'b0; wb_sel_mem = 2'b00;
    memdata_width_mem = 3'b000; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One load/store from IDLE through WB; called at posedge+1.
  task automatic run_mem(input string tag, input logic [63:0] pc, input logic [63:0] addr,
                         input logic [63:0] rs2, input logic [63:0] rdata, input logic we,
                         input logic [2:0] f3, input logic [7:0] exp_mask,
                         input logic [63:0] exp_wdata, input int req_wait, input int resp_wait);
    int stalls;
    logic [63:0] exp_addr;
    stalls   = 0;
    exp_addr = {addr[63:3], 3'b000};
    valid_mem = 1'b1; pc_mem = pc; inst_mem = we ? 32'h0000_0023 : 32'h0000_0003;
    alu_result_mem = addr; rs2_data_mem = rs2; re_mem = !we; we_mem = we;
    wb_sel_mem = we ? 2'b00 : 2'b10; memdata_width_mem = f3;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    if (stall_mem) stalls++;
    chk({tag, ".idle_no_req"}, {63'd0, mem_req_valid}, 64'd0);
    for (int i = 0; i <= req_wait; i++) begin
      step();
      mem_req_ready  = (i == req_wait);
      mem_resp_valid = (i != req_wait);  // stray response while requesting must be ignored
      mem_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
      rs2_data_mem   = ~rs2;             // request must come from the captured copy
      #1;
      if (stall_mem) stalls++;
      chk({tag, ".req_valid"}, {63'd0, mem_req_valid}, 64'd1);
      chk({tag, ".addr"},      mem_addr,               exp_addr);
      chk({tag, ".wmask"},     {56'd0, mem_wmask},     {56'd0, exp_mask});
      chk({tag, ".wdata"},     mem_wdata,              exp_wdata);
      chk({tag, ".we"},        {63'd0, mem_we},        {63'd0, we});
    end
    rs2_data_mem = rs2;
    for (int i = 0; i <= resp_wait; i++) begin
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = (i == resp_wait);
      mem_rdata      = rdata;
      #1;
      if (stall_mem) stalls++;
      chk({tag, ".wait_no_req"}, {63'd0, mem_req_valid}, 64'd0);
    end
    chk({tag, ".stall_cycles"}, 64'(stalls), 64'(2 + req_wait + resp_wait));
    step();
    mem_resp_valid = 1'b0;
    chk({tag, ".valid_wb"},   {63'd0, valid_wb}, 64'd1);
    chk({tag, ".pc_wb"},      pc_wb,             pc);
    chk({tag, ".alu_wb"},     alu_result_wb,     addr);
    chk({tag, ".data_in_wb"}, data_in_wb,        we ? 64'd0 : rdata);
    chk({tag, ".wb_sel_wb"},  {62'd0, wb_sel_wb}, we ? 64'd0 : 64'd2);
    chk({tag, ".width_wb"},   {61'd0, memdata_width_wb}, {61'd0, f3});
    valid_mem = 1'b0; re_mem = 1'b0; we_mem = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("rst.stall",     {63'd0, stall_mem},     64'd0);
    chk("rst.req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst.valid_wb",  {63'd0, valid_wb},      64'd0);
    chk("rst.addr",      mem_addr,               64'd0);
    chk("rst.wmask",     {56'd0, mem_wmask},     64'd0);
    chk("rst.data_in",   data_in_wb,             64'd0);
    chk("rst.misalign",  {63'd0, misalign_exc},  64'd0);

    // ADD: single-cycle pass-through
    step();
    valid_mem = 1'b1; pc_mem = 64'h100; inst_mem = 32'h00B5_0533;
    alu_result_mem = 64'h1234; wb_sel_mem = 2'b01;
    #1;
    chk("add.stall", {63'd0, stall_mem}, 64'd0);
    step();
    valid_mem = 1'b0;
    chk("add.valid_wb",  {63'd0, valid_wb}, 64'd1);
    chk("add.alu_wb",    alu_result_wb,     64'h1234);
    chk("add.pc_wb",     pc_wb,             64'h100);
    chk("add.inst_wb",   {32'd0, inst_wb},  64'h00B5_0533);
    chk("add.wb_sel_wb", {62'd0, wb_sel_wb}, 64'd1);
    chk("add.data_in",   data_in_wb,        64'd0);
    chk("add.stall2",    {63'd0, stall_mem}, 64'd0);
    step();
    chk("bubble.valid_wb", {63'd0, valid_wb}, 64'd0);

    // LD, ready at once, response on the second WAIT cycle
    run_mem("ld", 64'h104, 64'h1000, 64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0, 3'b011,
            8'hFF, 64'd0, 0, 1);

    // SB to byte 5, ready held off
    run_mem("sb", 64'h108, 64'h1005, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b000,
            8'h20, 64'h0000_AB00_0000_0000, 2, 0);

`ifdef MISALIGN_TRAP_EN
    valid_mem = 1'b1; pc_mem = 64'h10C; inst_mem = 32'h0000_2023;
    alu_result_mem = 64'h1006; rs2_data_mem = 64'h1122_3344; we_mem = 1'b1;
    wb_sel_mem = 2'b01; memdata_width_mem = 3'b010;
    #1;
    chk("sw_mis.stall",     {63'd0, stall_mem},     64'd0);
    chk("sw_mis.req_valid", {63'd0, mem_req_valid}, 64'd0);
    step();
    valid_mem = 1'b0; we_mem = 1'b0;
    chk("sw_mis.req_valid2", {63'd0, mem_req_valid}, 64'd0);
    chk("sw_mis.valid_wb",   {63'd0, valid_wb},      64'd1);
    chk("sw_mis.exc",        {63'd0, misalign_exc},  64'd1);
    chk("sw_mis.wb_sel",     {62'd0, wb_sel_wb},     64'd0);
    step();
    chk("sw_mis.exc_clear",  {63'd0, misalign_exc},  64'd0);
`else
    run_mem("sw_mis", 64'h10C, 64'h1006, 64'h1122_3344, 64'd0, 1'b1, 3'b010,
            8'hC0, 64'h3344_0000_0000_0000, 0, 0);
`endif

    // Async reset while waiting for a response
    valid_mem = 1'b1; pc_mem = 64'h110; alu_result_mem = 64'h3000; re_mem = 1'b1;
    wb_sel_mem = 2'b10; memdata_width_mem = 3'b011;
    step();
    mem_req_ready = 1'b1;
    step();
    idle_inputs();
    #1;
    chk("rstw.stall_before", {63'd0, stall_mem}, 64'd1);
    rstn = 1'b0;
    #1;
    chk("rstw.stall",     {63'd0, stall_mem},     64'd0);
    chk("rstw.req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rstw.addr",      mem_addr,               64'd0);
    chk("rstw.valid_wb",  {63'd0, valid_wb},      64'd0);
    chk("rstw.pc_wb",     pc_wb,                  64'd0);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    step();
    rstn = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("rstw.late_resp_valid_wb", {63'd0, valid_wb},  64'd0);
    chk("rstw.late_resp_stall",    {63'd0, stall_mem}, 64'd0);
    chk("rstw.late_resp_data",     data_in_wb,         64'd0);
    run_mem("ld_after_rst", 64'h114, 64'h3008, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0,
            3'b011, 8'hFF, 64'd0, 0, 0);

    // Back-to-back word loads
    run_mem("lw_hi", 64'h118, 64'h2004, 64'd0, 64'hAAAA_0001_BBBB_0002, 1'b0, 3'b010,
            8'hF0, 64'd0, 1, 0);
    run_mem("lw_lo", 64'h11C, 64'h2000, 64'd0, 64'hCCCC_0003_DDDD_0004, 1'b0, 3'b010,
            8'h0F, 64'd0, 0, 0);
    step();
    chk("b2b.tail_bubble", {63'd0, valid_wb}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
